// File: rtl/sum_block_accumulator_pkg.sv
// Shared types and helpers for the block accumulator that sits behind the
// registered ripple adder.
package sum_acc_pkg;

  localparam int SUM_W_DEF     = 4;
  localparam int ACC_W_DEF     = 8;
  localparam int BLOCK_LEN_DEF = 4;
  localparam int MAX_SUM_W     = 16;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Caller zero-extends sum to MAX_SUM_W; c_out lands just above the sum bits.
  function automatic logic [MAX_SUM_W:0] beat_value(
    input logic [MAX_SUM_W-1:0] sum,
    input logic                 c_out,
    input int                   sum_w
  );
    logic [MAX_SUM_W:0] v;
    v        = {1'b0, sum};
    v[sum_w] = c_out;
    return v;
  endfunction

endpackage

// File: rtl/sum_block_accumulator_sat_add.sv
// Unsigned saturating adder: clamps to all-ones when the true sum exceeds W bits.
module sat_add #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
  output logic         sat
);

  logic [W:0] s;

  assign s   = {1'b0, a} + {1'b0, b};
  assign sat = s[W];
  assign y   = s[W] ? {W{1'b1}} : s[W-1:0];

endmodule

// File: rtl/sum_block_accumulator.sv
// Accumulates {c_out,sum} beats into saturating block totals and presents each
// block on a valid/ready port; input is stalled while a result is pending.
module sum_block_accumulator
  import sum_acc_pkg::*;
#(
  parameter int SUM_W     = SUM_W_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int BLOCK_LEN = BLOCK_LEN_DEF,
  parameter int CNT_W     = $clog2(BLOCK_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] sum,
  input  logic             c_out,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] total,
  output logic [CNT_W-1:0] nsamp,
  output logic             overflow
);

  state_t             state_reg, state_next;
  logic [ACC_W-1:0]   acc_reg, acc_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               ovf_reg, ovf_next;
  logic [ACC_W-1:0]   total_reg, total_next;
  logic [CNT_W-1:0]   nsamp_reg, nsamp_next;
  logic               overflow_reg, overflow_next;

  logic [ACC_W-1:0]   beat;
  logic [ACC_W-1:0]   add_y;
  logic               add_sat;

  assign beat = ACC_W'(beat_value(MAX_SUM_W'(sum), c_out, SUM_W));

  sat_add #(.W(ACC_W)) u_sat_add (
    .a   (acc_reg),
    .b   (beat),
    .y   (add_y),
    .sat (add_sat)
  );

  always_comb begin
    state_next    = state_reg;
    acc_next      = acc_reg;
    cnt_next      = cnt_reg;
    ovf_next      = ovf_reg;
    total_next    = total_reg;
    nsamp_next    = nsamp_reg;
    overflow_next = overflow_reg;
    case (state_reg)
      ACCUM: begin
        if (in_valid) begin
          acc_next = add_y;
          ovf_next = ovf_reg | add_sat;
          cnt_next = cnt_reg + CNT_W'(1);
        end
        // Emit on a full block, or on flush when the block (including this beat) is non-empty.
        if (cnt_next == CNT_W'(BLOCK_LEN) || (flush && cnt_next != '0)) begin
          total_next    = acc_next;
          nsamp_next    = cnt_next;
          overflow_next = ovf_next;
          state_next    = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          acc_next   = '0;
          cnt_next   = '0;
          ovf_next   = 1'b0;
          state_next = ACCUM;
        end
      end
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ACCUM;
      acc_reg      <= '0;
      cnt_reg      <= '0;
      ovf_reg      <= 1'b0;
      total_reg    <= '0;
      nsamp_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      acc_reg      <= acc_next;
      cnt_reg      <= cnt_next;
      ovf_reg      <= ovf_next;
      total_reg    <= total_next;
      nsamp_reg    <= nsamp_next;
      overflow_reg <= overflow_next;
    end
  end

  assign in_ready  = (state_reg == ACCUM);
  assign out_valid = (state_reg == HOLD);
  assign total     = total_reg;
  assign nsamp     = nsamp_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_sum_block_accumulator.sv
// Drives an 8-bit and a 6-bit accumulator with identical stimulus and checks
// both against a block-level arithmetic model.
module tb_sum_block_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] sum;
  logic       c_out;
  logic       flush;
  logic       out_ready;

  logic       a_in_ready, a_out_valid, a_overflow;
  logic [7:0] a_total;
  logic [2:0] a_nsamp;
  logic       b_in_ready, b_out_valid, b_overflow;
  logic [5:0] b_total;
  logic [2:0] b_nsamp;

  int tests = 0;
  int fails = 0;

  // Model: per-block true sum; total is min(sum, max), overflow is sum > max.
  int  m_sum[2], m_cnt[2], m_total[2], m_nsamp[2];
  bit  m_hold[2], m_ovf[2];
  int  m_max[2] = '{255, 63};

  always #5 clk = ~clk;

  sum_block_accumulator dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .sum(sum), .c_out(c_out), .flush(flush), .out_valid(a_out_valid),
    .out_ready(out_ready), .total(a_total), .nsamp(a_nsamp), .overflow(a_overflow)
  );

  sum_block_accumulator #(.ACC_W(6)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .sum(sum), .c_out(c_out), .flush(flush), .out_valid(b_out_valid),
    .out_ready(out_ready), .total(b_total), .nsamp(b_nsamp), .overflow(b_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a_out_valid", 32'(a_out_valid), 32'(m_hold[0]));
    chk("a_in_ready",  32'(a_in_ready),  32'(!m_hold[0]));
    chk("a_total",     32'(a_total),     m_total[0]);
    chk("a_nsamp",     32'(a_nsamp),     m_nsamp[0]);
    chk("a_overflow",  32'(a_overflow),  32'(m_ovf[0]));
    chk("b_out_valid", 32'(b_out_valid), 32'(m_hold[1]));
    chk("b_in_ready",  32'(b_in_ready),  32'(!m_hold[1]));
    chk("b_total",     32'(b_total),     m_total[1]);
    chk("b_nsamp",     32'(b_nsamp),     m_nsamp[1]);
    chk("b_overflow",  32'(b_overflow),  32'(m_ovf[1]));
  endtask

  task automatic model_edge(input bit r, input bit iv, input int v, input bit fl, input bit ordy);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        m_hold[k] = 0; m_sum[k] = 0; m_cnt[k] = 0;
        m_total[k] = 0; m_nsamp[k] = 0; m_ovf[k] = 0;
      end else if (m_hold[k]) begin
        if (ordy) begin
          m_hold[k] = 0; m_sum[k] = 0; m_cnt[k] = 0;
        end
      end else begin
        if (iv) begin
          m_sum[k] += v;
          m_cnt[k]++;
        end
        if (m_cnt[k] == 4 || (fl && m_cnt[k] > 0)) begin
          m_total[k] = (m_sum[k] > m_max[k]) ? m_max[k] : m_sum[k];
          m_nsamp[k] = m_cnt[k];
          m_ovf[k]   = (m_sum[k] > m_max[k]);
          m_hold[k]  = 1;
        end
      end
    end
  endtask

  // One clock: check current outputs, then drive the next cycle's inputs.
  task automatic cyc(input bit r, input bit iv, input int v, input bit fl, input bit ordy);
    logic [4:0] bv;
    @(negedge clk);
    check_all();
    bv        = v[4:0];
    rst       = r;
    in_valid  = iv;
    sum       = bv[3:0];
    c_out     = bv[4];
    flush     = fl;
    out_ready = ordy;
    model_edge(r, iv, v, fl, ordy);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; sum = '0; c_out = 1'b0; flush = 1'b0; out_ready = 1'b1;
    model_edge(1, 0, 0, 0, 1);
    @(posedge clk);
    @(posedge clk);

    // Basic block 1,2,3,4
    cyc(0, 1, 1, 0, 1); cyc(0, 1, 2, 0, 1); cyc(0, 1, 3, 0, 1); cyc(0, 1, 4, 0, 1);
    settle();
    chk("basic_valid", 32'(a_out_valid), 1);
    chk("basic_total", 32'(a_total), 10);
    chk("basic_nsamp", 32'(a_nsamp), 4);
    cyc(0, 0, 0, 0, 1);
    settle();
    chk("basic_ready_after", 32'(a_in_ready), 1);

    // Carry path, and saturation in the 6-bit instance
    for (int i = 0; i < 4; i++) cyc(0, 1, 31, 0, 1);
    settle();
    chk("carry_total", 32'(a_total), 124);
    chk("carry_ovf", 32'(a_overflow), 0);
    chk("sat_total", 32'(b_total), 63);
    chk("sat_ovf", 32'(b_overflow), 1);
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 1);
    settle();
    chk("sat_next_total", 32'(b_total), 4);
    chk("sat_next_ovf", 32'(b_overflow), 0);
    cyc(0, 0, 0, 0, 1);

    // Backpressure
    for (int i = 0; i < 4; i++) cyc(0, 1, 2, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 7, 0, 0);
    settle();
    chk("bp_valid", 32'(a_out_valid), 1);
    chk("bp_total", 32'(a_total), 8);
    chk("bp_in_ready", 32'(a_in_ready), 0);
    cyc(0, 1, 7, 0, 1);
    settle();
    chk("bp_released", 32'(a_out_valid), 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 1);
    settle();
    chk("bp_fresh_total", 32'(a_total), 4);
    cyc(0, 0, 0, 0, 1);

    // Flush variants
    cyc(0, 1, 5, 0, 1); cyc(0, 1, 6, 0, 1); cyc(0, 0, 0, 1, 1);
    settle();
    chk("flush_total", 32'(a_total), 11);
    chk("flush_nsamp", 32'(a_nsamp), 2);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 5, 0, 1); cyc(0, 1, 9, 1, 1);
    settle();
    chk("flush_beat_total", 32'(a_total), 14);
    chk("flush_beat_nsamp", 32'(a_nsamp), 2);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 1);
    settle();
    chk("flush_empty", 32'(a_out_valid), 0);

    // Reset mid-block and during HOLD
    cyc(0, 1, 3, 0, 1); cyc(0, 1, 3, 0, 1); cyc(1, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 1);
    settle();
    chk("rst_mid_total", 32'(a_total), 4);
    chk("rst_mid_nsamp", 32'(a_nsamp), 4);
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 1, 2, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    settle();
    chk("rst_hold_valid", 32'(a_out_valid), 0);
    chk("rst_hold_total", 32'(a_total), 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 63) == 0), 1'($urandom), int'($urandom_range(0, 31)),
          ($urandom_range(0, 7) == 0), 1'($urandom));
    end
    @(negedge clk);
    check_all();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
